// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_arbiter_if
//  Purpose  : Bundles the requester handshake, response and memory-macro
//             signals of the memory bus arbiter.
//  Ports    : req_valid/req_we/req_addr/req_wdata  - requester requests
//             req_ready                            - one-hot grant
//             rsp_valid/rsp_rdata                  - completion pulse + data
//             mem_en/mem_we/mem_addr/mem_wdata     - memory macro strobes
//             mem_rdata                            - memory read data
//  Modports : slave  - the arbiter
//             master - requesters and memory model (environment side)
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_bus_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = 32,
    parameter int DW   = 32
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_rdata;
    logic               mem_en;
    logic               mem_we;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic [DW-1:0]      mem_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_arbiter
//  Purpose  : Round-robin arbiter sharing one single-port memory bus between
//             NREQ requesters (0 = ifetch, 1 = load/store, 2 = DMA/IO).
//             One transaction at a time: IDLE -> ISSUE -> WAIT* -> RESP.
//  Ports    : clock     - system clock, rising edge
//             reset     - asynchronous, active-high
//             bus       - mem_bus_arbiter_if.slave (requests, responses,
//                         memory macro signals)
//             busy      - high whenever the FSM is not in IDLE
//             grant_id  - index of the current / most recent grant
//  Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int NREQ        = 3,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    mem_bus_arbiter_if.slave     bus,
    output logic                 busy,
    output logic [2:0]           grant_id
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    logic [2:0]      ptr;
    logic [2:0]      cap_id;
    logic [3:0]      wait_cnt;

    logic            sel_found;
    logic [2:0]      sel_id;
    logic            sel_we;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic [NREQ-1:0] cap_onehot;

    // Round-robin pick: scan candidates ptr, ptr+1, ... (mod NREQ) and take
    // the first valid one. The outer loop fixes priority order.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = 3'd0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!sel_found && bus.req_valid[i] && (i == ((int'(ptr) + k) % NREQ))) begin
                    sel_found = 1'b1;
                    sel_id    = 3'(i);
                    sel_we    = bus.req_we[i];
                    sel_addr  = bus.req_addr[i*AW +: AW];
                    sel_wdata = bus.req_wdata[i*DW +: DW];
                end
            end
        end
    end

    // Grant is combinational in IDLE only; held low while reset is asserted
    // so every output reads zero during reset.
    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_ready[i] = !reset && (state == IDLE) && sel_found && (sel_id == 3'(i));
        end
    end

    always_comb begin
        cap_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            cap_onehot[i] = (cap_id == 3'(i));
        end
    end

    assign busy = (state != IDLE);

    // mem_we / mem_addr / mem_wdata double as the captured request fields:
    // loaded on accept and held until the next accept.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            ptr           <= 3'd0;
            cap_id        <= 3'd0;
            wait_cnt      <= 4'd0;
            grant_id      <= 3'd0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        cap_id        <= sel_id;
                        grant_id      <= sel_id;
                        ptr           <= (sel_id == 3'(NREQ - 1)) ? 3'd0 : sel_id + 3'd1;
                        bus.mem_we    <= sel_we;
                        bus.mem_addr  <= sel_addr;
                        bus.mem_wdata <= sel_wdata;
                        bus.mem_en    <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.mem_en <= 1'b0;
                    wait_cnt   <= 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        // Zero-latency memory: data is valid in the issue cycle.
                        bus.rsp_valid <= cap_onehot;
                        bus.rsp_rdata <= bus.mem_we ? '0 : bus.mem_rdata;
                        state         <= RESP;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt <= 4'd1) begin
                        bus.rsp_valid <= cap_onehot;
                        bus.rsp_rdata <= bus.mem_we ? '0 : bus.mem_rdata;
                        wait_cnt      <= 4'd0;
                        state         <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    bus.rsp_valid <= '0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_bus_arbiter
//  Purpose  : Directed self-checking bench for mem_bus_arbiter. Three
//             instances share clock/reset: WAIT_CYCLES = 1 (main), 0 and 3.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    logic       clock;
    logic       reset;
    logic       busy1, busy0, busy3;
    logic [2:0] gid1, gid0, gid3;
    int         checks;
    int         errors;

    mem_bus_arbiter_if #(.NREQ(3), .AW(32), .DW(32)) bus1 ();
    mem_bus_arbiter_if #(.NREQ(3), .AW(32), .DW(32)) bus0 ();
    mem_bus_arbiter_if #(.NREQ(3), .AW(32), .DW(32)) bus3 ();

    mem_bus_arbiter #(.NREQ(3), .AW(32), .DW(32), .WAIT_CYCLES(1)) dut1 (
        .clock(clock), .reset(reset), .bus(bus1), .busy(busy1), .grant_id(gid1));
    mem_bus_arbiter #(.NREQ(3), .AW(32), .DW(32), .WAIT_CYCLES(0)) dut0 (
        .clock(clock), .reset(reset), .bus(bus0), .busy(busy0), .grant_id(gid0));
    mem_bus_arbiter #(.NREQ(3), .AW(32), .DW(32), .WAIT_CYCLES(3)) dut3 (
        .clock(clock), .reset(reset), .bus(bus3), .busy(busy3), .grant_id(gid3));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [2:0] exp_oh;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus1.req_valid = '0; bus1.req_we = '0; bus1.req_addr = '0; bus1.req_wdata = '0; bus1.mem_rdata = '0;
        bus0.req_valid = '0; bus0.req_we = '0; bus0.req_addr = '0; bus0.req_wdata = '0; bus0.mem_rdata = '0;
        bus3.req_valid = '0; bus3.req_we = '0; bus3.req_addr = '0; bus3.req_wdata = '0; bus3.mem_rdata = '0;

        // ---------------- reset state ----------------
        tick;
        bus1.req_valid = 3'b111;
        #1;
        check("rst_ready", 32'(bus1.req_ready), 32'h0);
        check("rst_rsp_valid", 32'(bus1.rsp_valid), 32'h0);
        check("rst_mem_en", 32'(bus1.mem_en), 32'h0);
        check("rst_busy", 32'(busy1), 32'h0);
        check("rst_grant_id", 32'(gid1), 32'h0);
        bus1.req_valid = 3'b000;
        tick;
        reset = 1'b0;
        tick;

        // ---------------- read, WAIT_CYCLES=1 ----------------
        bus1.req_valid = 3'b001;
        bus1.req_addr[31:0]  = 32'h10;
        bus1.req_wdata[31:0] = 32'h0000ABCD;
        bus1.mem_rdata = 32'hDEADBEEF;
        #1;
        check("rd_ready_T", 32'(bus1.req_ready), 32'h1);
        tick;                                   // T+1
        check("rd_ready_issue", 32'(bus1.req_ready), 32'h0);
        bus1.req_valid = 3'b000;
        bus1.req_addr[31:0] = 32'hFFFF;         // captured value must be used
        check("rd_mem_en", 32'(bus1.mem_en), 32'h1);
        check("rd_mem_we", 32'(bus1.mem_we), 32'h0);
        check("rd_mem_addr", bus1.mem_addr, 32'h10);
        check("rd_busy", 32'(busy1), 32'h1);
        tick;                                   // T+2
        check("rd_mem_en_off", 32'(bus1.mem_en), 32'h0);
        check("rd_no_early_rsp", 32'(bus1.rsp_valid), 32'h0);
        tick;                                   // T+3
        check("rd_rsp_valid", 32'(bus1.rsp_valid), 32'h1);
        check("rd_rsp_rdata", bus1.rsp_rdata, 32'hDEADBEEF);
        check("rd_grant_id", 32'(gid1), 32'h0);
        tick;                                   // T+4
        check("rd_rsp_end", 32'(bus1.rsp_valid), 32'h0);
        check("rd_idle", 32'(busy1), 32'h0);

        // ---------------- write from requester 2 ----------------
        bus1.req_valid = 3'b100;
        bus1.req_we    = 3'b100;
        bus1.req_addr[64 +: 32]  = 32'h200;
        bus1.req_wdata[64 +: 32] = 32'hCAFEF00D;
        bus1.mem_rdata = 32'h12345678;
        #1;
        check("wr_ready", 32'(bus1.req_ready), 32'h4);
        tick;
        bus1.req_valid = 3'b000;
        bus1.req_we    = 3'b000;
        bus1.req_wdata[64 +: 32] = 32'h0;
        check("wr_mem_en", 32'(bus1.mem_en), 32'h1);
        check("wr_mem_we", 32'(bus1.mem_we), 32'h1);
        check("wr_mem_addr", bus1.mem_addr, 32'h200);
        check("wr_mem_wdata", bus1.mem_wdata, 32'hCAFEF00D);
        tick;
        check("wr_mem_en_once", 32'(bus1.mem_en), 32'h0);
        tick;
        check("wr_rsp_valid", 32'(bus1.rsp_valid), 32'h4);
        check("wr_rsp_rdata", bus1.rsp_rdata, 32'h0);
        check("wr_grant_id", 32'(gid1), 32'h2);
        tick;

        // ---------------- fairness, all three requesting ----------------
        bus1.req_valid = 3'b111;
        for (int g = 0; g < 6; g++) begin
            exp_oh = 3'(1 << (g % 3));
            #1;
            check("rr_ready", 32'(bus1.req_ready), 32'(exp_oh));
            tick;
            check("rr_ready_busy", 32'(bus1.req_ready), 32'h0);
            tick;
            tick;
            check("rr_rsp_valid", 32'(bus1.rsp_valid), 32'(exp_oh));
            check("rr_grant_id", 32'(gid1), 32'(g % 3));
            tick;
        end
        bus1.req_valid = 3'b000;

        // pointer must not move while idle
        tick; tick; tick;

        // ---------------- wrap: grant 1, then 0 before 1 ----------------
        bus1.mem_rdata = 32'h00000077;
        bus1.req_valid = 3'b010;
        #1;
        check("wrap_pre", 32'(bus1.req_ready), 32'h2);
        tick;
        bus1.req_valid = 3'b000;
        tick; tick; tick;
        bus1.req_valid = 3'b011;
        #1;
        check("wrap_first", 32'(bus1.req_ready), 32'h1);
        tick; tick; tick;
        check("wrap_first_rsp", 32'(bus1.rsp_valid), 32'h1);
        tick;
        check("wrap_second", 32'(bus1.req_ready), 32'h2);
        tick;
        bus1.req_valid = 3'b000;
        tick; tick;
        check("wrap_second_rsp", 32'(bus1.rsp_valid), 32'h2);
        tick;

        // ---------------- reset during WAIT ----------------
        bus1.req_valid = 3'b001;
        bus1.req_addr[31:0] = 32'h300;
        bus1.mem_rdata = 32'h55555555;
        #1;
        check("abort_ready", 32'(bus1.req_ready), 32'h1);
        tick;                                   // ISSUE
        bus1.req_valid = 3'b000;
        tick;                                   // WAIT
        check("abort_busy", 32'(busy1), 32'h1);
        reset = 1'b1;
        #1;
        check("abort_ready0", 32'(bus1.req_ready), 32'h0);
        check("abort_rsp_valid", 32'(bus1.rsp_valid), 32'h0);
        check("abort_rsp_rdata", bus1.rsp_rdata, 32'h0);
        check("abort_mem_en", 32'(bus1.mem_en), 32'h0);
        check("abort_mem_addr", bus1.mem_addr, 32'h0);
        check("abort_mem_wdata", bus1.mem_wdata, 32'h0);
        check("abort_busy0", 32'(busy1), 32'h0);
        tick;
        reset = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick;
            check("abort_no_rsp", 32'(bus1.rsp_valid), 32'h0);
        end
        bus1.req_valid = 3'b111;
        #1;
        check("post_reset_grant", 32'(bus1.req_ready), 32'h1);
        tick;
        bus1.req_valid = 3'b000;

        // ---------------- WAIT_CYCLES=0: data sampled in the issue cycle ----------------
        bus0.req_valid = 3'b001;
        bus0.req_addr[31:0] = 32'h40;
        bus0.mem_rdata = 32'hA0000000;
        #1;
        check("w0_ready", 32'(bus0.req_ready), 32'h1);
        for (int n = 1; n <= 2; n++) begin
            tick;
            bus0.req_valid = 3'b000;
            bus0.mem_rdata = 32'hA0000000 + 32'(n);
            if (n == 1) begin
                check("w0_mem_en", 32'(bus0.mem_en), 32'h1);
                check("w0_no_rsp", 32'(bus0.rsp_valid), 32'h0);
            end else begin
                check("w0_rsp_valid", 32'(bus0.rsp_valid), 32'h1);
                check("w0_rsp_rdata", bus0.rsp_rdata, 32'hA0000001);
            end
        end

        // ---------------- WAIT_CYCLES=3: data sampled at end of T+4 ----------------
        bus3.req_valid = 3'b001;
        bus3.req_addr[31:0] = 32'h80;
        bus3.mem_rdata = 32'hB0000000;
        #1;
        check("w3_ready", 32'(bus3.req_ready), 32'h1);
        for (int n = 1; n <= 5; n++) begin
            tick;
            bus3.req_valid = 3'b000;
            bus3.mem_rdata = 32'hB0000000 + 32'(n);
            if (n == 1) check("w3_mem_en", 32'(bus3.mem_en), 32'h1);
            if (n < 5) begin
                check("w3_no_rsp", 32'(bus3.rsp_valid), 32'h0);
            end else begin
                check("w3_rsp_valid", 32'(bus3.rsp_valid), 32'h1);
                check("w3_rsp_rdata", bus3.rsp_rdata, 32'hB0000004);
            end
        end
        tick;
        check("w3_rsp_end", 32'(bus3.rsp_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
